// File: rtl/tlb_cmd_unit.sv
// Joint-TLB entry array plus the sequencer for TLBR/TLBWI/TLBWR/TLBP.
// Commands capture their CP0 operands at accept; TLBP walks entries one per cycle.
module tlb_cmd_unit #(
  parameter int TLB_LINE  = 16,
  parameter int TLB_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  tlbcmd_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cp0_index_i,
  input  logic [31:0] cp0_random_i,
  input  logic [31:0] cp0_pagemask_i,
  input  logic [31:0] cp0_entryhi_i,
  input  logic [31:0] cp0_entrylo0_i,
  input  logic [31:0] cp0_entrylo1_i,
  output logic [31:0] index_o,
  output logic [31:0] pagemask_o,
  output logic [31:0] entryhi_o,
  output logic [31:0] entrylo0_o,
  output logic [31:0] entrylo1_o,
  output logic        index_we_o,
  output logic        entry_we_o,
  output logic        done_o
);
  localparam logic [3:0] OP_TLBR  = 4'd1;
  localparam logic [3:0] OP_TLBWR = 4'd3;
  localparam logic [3:0] OP_TLBP  = 4'd4;
  localparam logic [TLB_WIDTH-1:0] LAST = TLB_WIDTH'(TLB_LINE - 1);

  typedef enum logic [1:0] {IDLE, EXEC, SCAN, DONE} state_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [15:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  state_t               state;
  tlb_entry_t           tlb [TLB_LINE];
  tlb_entry_t           ent_q, new_ent, cur, rd;
  logic [3:0]           op_q;
  logic [TLB_WIDTH-1:0] sel_q, ptr;
  logic                 accept, hit;

  assign cmd_ready_o = (state == IDLE);
  assign accept = cmd_valid_i && cmd_ready_o && (tlbcmd_i >= OP_TLBR) && (tlbcmd_i <= OP_TLBP);

  always_comb begin
    new_ent      = '0;
    new_ent.vpn2 = cp0_entryhi_i[31:13];
    new_ent.asid = cp0_entryhi_i[7:0];
    new_ent.mask = cp0_pagemask_i[28:13];
    new_ent.g    = cp0_entrylo0_i[0] & cp0_entrylo1_i[0];
    new_ent.pfn0 = cp0_entrylo0_i[25:6];
    new_ent.c0   = cp0_entrylo0_i[5:3];
    new_ent.d0   = cp0_entrylo0_i[2];
    new_ent.v0   = cp0_entrylo0_i[1];
    new_ent.pfn1 = cp0_entrylo1_i[25:6];
    new_ent.c1   = cp0_entrylo1_i[5:3];
    new_ent.d1   = cp0_entrylo1_i[2];
    new_ent.v1   = cp0_entrylo1_i[1];
  end

  // Probe compare: the stored entry's mask hides low VPN2 bits; V is deliberately ignored.
  assign cur = tlb[ptr];
  assign rd  = tlb[sel_q];
  assign hit = (cur.vpn2[18:16] == ent_q.vpn2[18:16]) &&
               (((cur.vpn2[15:0] ^ ent_q.vpn2[15:0]) & ~cur.mask) == 16'd0) &&
               (cur.g || (cur.asid == ent_q.asid));

  logic unused_ok;
  assign unused_ok = ^{cp0_index_i[31:TLB_WIDTH], cp0_random_i[31:TLB_WIDTH],
                       cp0_pagemask_i[31:29], cp0_pagemask_i[12:0], cp0_entryhi_i[12:8],
                       cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      sel_q      <= '0;
      ptr        <= '0;
      ent_q      <= '0;
      index_o    <= '0;
      pagemask_o <= '0;
      entryhi_o  <= '0;
      entrylo0_o <= '0;
      entrylo1_o <= '0;
      index_we_o <= 1'b0;
      entry_we_o <= 1'b0;
      done_o     <= 1'b0;
      for (int i = 0; i < TLB_LINE; i++) tlb[i] <= '0;
    end else begin
      done_o     <= 1'b0;
      index_we_o <= 1'b0;
      entry_we_o <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q  <= tlbcmd_i;
          sel_q <= (tlbcmd_i == OP_TLBWR) ? cp0_random_i[TLB_WIDTH-1:0]
                                          : cp0_index_i[TLB_WIDTH-1:0];
          ent_q <= new_ent;
          ptr   <= '0;
          state <= (tlbcmd_i == OP_TLBP) ? SCAN : EXEC;
        end
        EXEC: begin
          if (op_q == OP_TLBR) begin
            pagemask_o <= {3'b0, rd.mask, 13'b0};
            entryhi_o  <= {rd.vpn2, 5'b0, rd.asid};
            entrylo0_o <= {6'b0, rd.pfn0, rd.c0, rd.d0, rd.v0, rd.g};
            entrylo1_o <= {6'b0, rd.pfn1, rd.c1, rd.d1, rd.v1, rd.g};
            entry_we_o <= 1'b1;
          end else begin
            tlb[sel_q] <= ent_q;
          end
          done_o <= 1'b1;
          state  <= DONE;
        end
        SCAN: begin
          if (hit || ptr == LAST) begin
            index_o    <= hit ? {{(32-TLB_WIDTH){1'b0}}, ptr} : 32'h8000_0000;
            index_we_o <= 1'b1;
            done_o     <= 1'b1;
            state      <= DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_cmd_unit.sv
// Random + directed bench for tlb_cmd_unit against a cycle-accurate behavioural model.
module tb_tlb_cmd_unit;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tlbcmd;
  logic        cmd_valid, cmd_ready;
  logic [31:0] c_idx, c_rnd, c_pm, c_hi, c_lo0, c_lo1;
  logic [31:0] index_o, pagemask_o, entryhi_o, entrylo0_o, entrylo1_o;
  logic        index_we, entry_we, done;

  tlb_cmd_unit #(.TLB_LINE(N), .TLB_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tlbcmd_i(tlbcmd), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready), .cp0_index_i(c_idx), .cp0_random_i(c_rnd),
    .cp0_pagemask_i(c_pm), .cp0_entryhi_i(c_hi), .cp0_entrylo0_i(c_lo0),
    .cp0_entrylo1_i(c_lo1), .index_o(index_o), .pagemask_o(pagemask_o),
    .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .index_we_o(index_we), .entry_we_o(entry_we), .done_o(done)
  );

  always #5 clk = ~clk;

  // Model: entries stored in their TLBR read-back form.
  logic [31:0] m_hi [N], m_pm [N], m_lo0 [N], m_lo1 [N];
  logic        e_ready, e_done, e_ewe, e_iwe;
  logic [31:0] e_idx, e_pm, e_hi, e_lo0, e_lo1;
  int  n_pass = 0, n_tot = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, e_ready});
    chk("done",      {31'b0, done},      {31'b0, e_done});
    chk("entry_we",  {31'b0, entry_we},  {31'b0, e_ewe});
    chk("index_we",  {31'b0, index_we},  {31'b0, e_iwe});
    chk("index_o",    index_o,    e_idx);
    chk("pagemask_o", pagemask_o, e_pm);
    chk("entryhi_o",  entryhi_o,  e_hi);
    chk("entrylo0_o", entrylo0_o, e_lo0);
    chk("entrylo1_o", entrylo1_o, e_lo1);
  end

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_hi[i] = 0; m_pm[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0;
    end
    e_ready = 1; e_done = 0; e_ewe = 0; e_iwe = 0;
    e_idx = 0; e_pm = 0; e_hi = 0; e_lo0 = 0; e_lo1 = 0;
  endtask

  function automatic int m_probe(input logic [31:0] hi);
    for (int i = 0; i < N; i++) begin
      logic [18:0] care;
      care = ~{3'b0, m_pm[i][28:13]};
      if ((((m_hi[i][31:13] ^ hi[31:13]) & care) == 19'd0) &&
          (m_lo0[i][0] || m_hi[i][7:0] == hi[7:0]))
        return i;
    end
    return -1;
  endfunction

  // Issue one command; lat is the cycle number of DONE counting the accept edge as end of cycle 0.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] idx, rnd, pm, hi, lo0, lo1,
                         output int lat);
    int s, h;
    logic g;
    @(negedge clk);
    tlbcmd = op; c_idx = idx; c_rnd = rnd; c_pm = pm; c_hi = hi; c_lo0 = lo0; c_lo1 = lo1;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    tlbcmd = 4'($urandom); c_idx = $urandom; c_rnd = $urandom; c_pm = $urandom;
    c_hi = $urandom; c_lo0 = $urandom; c_lo1 = $urandom;
    lat = 0;
    if (op < 4'd1 || op > 4'd4) return;
    e_ready = 0;
    s = (op == 4'd3) ? int'(rnd[3:0]) : int'(idx[3:0]);
    h = m_probe(hi);
    lat = (op != 4'd4) ? 2 : (h >= 0 ? h + 2 : N + 1);
    repeat (lat - 1) @(posedge clk);
    #1;
    e_done = 1;
    case (op)
      4'd1: begin
        e_pm = m_pm[s]; e_hi = m_hi[s]; e_lo0 = m_lo0[s]; e_lo1 = m_lo1[s]; e_ewe = 1;
      end
      4'd4: begin
        e_iwe = 1;
        e_idx = (h >= 0) ? 32'(h) : 32'h8000_0000;
      end
      default: begin
        g = lo0[0] & lo1[0];
        m_hi[s]  = {hi[31:13], 5'b0, hi[7:0]};
        m_pm[s]  = {3'b0, pm[28:13], 13'b0};
        m_lo0[s] = {6'b0, lo0[25:1], g};
        m_lo1[s] = {6'b0, lo1[25:1], g};
      end
    endcase
    @(posedge clk); #1;
    e_done = 0; e_ewe = 0; e_iwe = 0; e_ready = 1;
  endtask

  initial begin
    int lat;
    tlbcmd = 0; cmd_valid = 0;
    c_idx = 0; c_rnd = 0; c_pm = 0; c_hi = 0; c_lo0 = 0; c_lo1 = 0;
    m_reset();
    rst_n = 1;
    #1 rst_n = 0;
    #1 chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready_lit", {31'b0, cmd_ready}, 32'd1);
    rst_n = 1;

    run_cmd(4'd4, 0, 0, 0, 32'h0, 0, 0, lat);
    chk("probe_zero_idx", index_o, 32'd0);
    chk("probe_zero_lat", 32'(lat), 32'd2);

    run_cmd(4'd2, 32'd5, 0, 0, 32'h1234_6012, 32'h0000_1247, 32'h0000_2047, lat);
    run_cmd(4'd1, 32'd5, 0, 0, 0, 0, 0, lat);
    chk("tlbr_hi",  entryhi_o,  32'h1234_6012);
    chk("tlbr_lo0", entrylo0_o, 32'h0000_1247);
    chk("tlbr_lo1", entrylo1_o, 32'h0000_2047);
    chk("tlbr_pm",  pagemask_o, 32'h0);
    chk("tlbr_lat", 32'(lat), 32'd2);

    run_cmd(4'd4, 0, 0, 0, 32'h1234_6055, 0, 0, lat);
    chk("probe_g_idx", index_o, 32'd5);
    chk("probe_g_lat", 32'(lat), 32'd7);

    run_cmd(4'd3, 0, 32'd3, 0, 32'h0040_000A, 32'h2, 32'h2, lat);
    run_cmd(4'd4, 0, 0, 0, 32'h0040_000B, 0, 0, lat);
    chk("probe_miss_idx", index_o, 32'h8000_0000);
    chk("probe_miss_lat", 32'(lat), 32'd17);
    run_cmd(4'd4, 0, 0, 0, 32'h0040_000A, 0, 0, lat);
    chk("probe_asid_idx", index_o, 32'd3);
    chk("probe_asid_lat", 32'(lat), 32'd5);

    run_cmd(4'd2, 32'd7, 0, 32'h0000_6000, 32'h7000_2000, 32'h1, 32'h1, lat);
    run_cmd(4'd4, 0, 0, 0, 32'h7000_0000, 0, 0, lat);
    chk("probe_mask_idx", index_o, 32'd7);

    run_cmd(4'd0, 0, 0, 0, 0, 0, 0, lat);
    run_cmd(4'd9, 0, 0, 0, 0, 0, 0, lat);

    // Abort a miss-bound TLBP with reset during its fourth SCAN cycle.
    @(negedge clk);
    tlbcmd = 4'd4; c_hi = 32'h0040_000B; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0; e_ready = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_cmd(4'd1, 32'd5, 0, 0, 0, 0, 0, lat);
    chk("post_rst_hi",  entryhi_o,  32'h0);
    chk("post_rst_lo0", entrylo0_o, 32'h0);

    for (int k = 0; k < 150; k++) begin
      int r, j;
      logic [3:0]  op;
      logic [31:0] pm, hi;
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 4'($urandom_range(5, 15)) : (r <= 2) ? 4'd1 : (r <= 4) ? 4'd2 :
           (r == 5) ? 4'd3 : 4'd4;
      pm = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h0001_E000) : 32'h0;
      hi = $urandom;
      if (op == 4'd4 && $urandom_range(0, 2) != 0) begin
        j  = $urandom_range(0, N - 1);
        hi = m_hi[j];
        hi[31:13] = hi[31:13] ^ (19'($urandom) & {3'b0, m_pm[j][28:13]});
        if ($urandom_range(0, 1) == 1) hi[7:0] = 8'($urandom);
      end
      run_cmd(op, $urandom, $urandom, pm, hi, $urandom, $urandom, lat);
    end

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
